// File: rtl/dcf77_frame_decoder.sv
// ============================================================================
// dcf77_frame_decoder : assembles DCF77 minute frames, validates, drives date/time
// Revision 1.0
// ============================================================================
`default_nettype none

module dcf77_frame_decoder #(
  parameter int MAX_MISSED = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_strobe,
  input  logic       bit_value,
  input  logic       minute_mark,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [2:0] day_of_week,
  output logic       valid,
  output logic       frame_ok,
  output logic       frame_error
);

  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSED);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  state_t      state;
  logic [59:0] frame;
  logic [5:0]  bit_count;
  logic [3:0]  miss_count;

  logic [7:0] f_minute, f_hour, f_day, f_month, f_year;
  logic [2:0] f_dow;
  logic [7:0] sec_max, sec_next;
  logic [3:0] miss_next;
  logic       len_ok, mark_ok, parity_ok, bcd_ok, range_ok, frame_good;
  logic       unused_bits;

  // Field slices are contiguous in the buffer, so each BCD byte is a direct slice.
  assign f_minute = {1'b0, frame[27:21]};
  assign f_hour   = {2'b0, frame[34:29]};
  assign f_day    = {2'b0, frame[41:36]};
  assign f_dow    = frame[44:42];
  assign f_month  = {3'b0, frame[49:45]};
  assign f_year   = frame[57:50];

  // Civil-warning and announcement bits carry no date/time content.
  assign unused_bits = ^frame[18:1];

  assign len_ok    = (bit_count == 6'd59) ||
                     ((bit_count == 6'd60) && frame[19] && !frame[59]);
  assign mark_ok   = !frame[0] && frame[20];
  assign parity_ok = !(^frame[28:21]) && !(^frame[35:29]) && !(^frame[58:36]);
  assign bcd_ok    = (f_minute[3:0] <= 4'd9) && (f_hour[3:0] <= 4'd9) &&
                     (f_day[3:0] <= 4'd9) && (f_month[3:0] <= 4'd9) &&
                     (f_year[3:0] <= 4'd9);
  assign range_ok  = (f_minute <= 8'h59) && (f_hour <= 8'h23) &&
                     (f_day != 8'h00) && (f_day <= 8'h31) &&
                     (f_month != 8'h00) && (f_month <= 8'h12) &&
                     (f_dow != 3'd0);
  assign frame_good = len_ok && mark_ok && parity_ok && bcd_ok && range_ok;

  assign miss_next = (miss_count == 4'hF) ? miss_count : miss_count + 4'd1;
  assign sec_max   = frame[19] ? 8'h60 : 8'h59;

  always_comb begin
    sec_next = second;
    if (second < sec_max) begin
      if (second[3:0] == 4'd9) sec_next = {second[7:4] + 4'd1, 4'd0};
      else                     sec_next = second + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      frame       <= '0;
      bit_count   <= '0;
      miss_count  <= '0;
      year        <= '0;
      month       <= '0;
      day         <= '0;
      hour        <= '0;
      minute      <= '0;
      second      <= '0;
      day_of_week <= '0;
      valid       <= 1'b0;
      frame_ok    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_ok    <= 1'b0;
      frame_error <= 1'b0;
      if (minute_mark) begin
        // The mark always restarts reception; the strobe in the same cycle is dropped.
        state     <= RECEIVE;
        bit_count <= '0;
        frame     <= '0;
        if (state == RECEIVE) begin
          second <= 8'h00;
          if (frame_good) begin
            year        <= f_year;
            month       <= f_month;
            day         <= f_day;
            hour        <= f_hour;
            minute      <= f_minute;
            day_of_week <= f_dow;
            valid       <= 1'b1;
            miss_count  <= '0;
            frame_ok    <= 1'b1;
          end else begin
            frame_error <= 1'b1;
            miss_count  <= miss_next;
            if (miss_next >= MISS_LIMIT) valid <= 1'b0;
          end
        end
      end else if (bit_strobe && (state == RECEIVE)) begin
        if (bit_count == 6'd60) begin
          // A 61st bit means the minute mark was lost: give up and re-sync.
          state       <= HUNT;
          frame_error <= 1'b1;
          miss_count  <= miss_next;
          if (miss_next >= MISS_LIMIT) valid <= 1'b0;
        end else begin
          frame[bit_count] <= bit_value;
          bit_count        <= bit_count + 6'd1;
          second           <= sec_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcf77_frame_decoder.sv
// ============================================================================
// tb_dcf77_frame_decoder : randomized frames checked against a decimal-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dcf77_frame_decoder;

  localparam int MAX_MISSED = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_strobe = 1'b0;
  logic       bit_value = 1'b0;
  logic       minute_mark = 1'b0;
  logic [7:0] year, month, day, hour, minute, second;
  logic [2:0] day_of_week;
  logic       valid, frame_ok, frame_error;

  int errors = 0;
  int checks = 0;

  dcf77_frame_decoder #(.MAX_MISSED(MAX_MISSED)) dut (
    .clk(clk), .reset(reset), .bit_strobe(bit_strobe), .bit_value(bit_value),
    .minute_mark(minute_mark), .year(year), .month(month), .day(day),
    .hour(hour), .minute(minute), .second(second), .day_of_week(day_of_week),
    .valid(valid), .frame_ok(frame_ok), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: decimal seconds counter and the received bits as a queue.
  bit         m_synced;
  bit         mq[$];
  int         m_sec, m_miss;
  bit         m_valid, m_ok, m_err;
  logic [7:0] m_year, m_month, m_day, m_hour, m_minute;
  logic [2:0] m_dow;

  bit         fb[60];
  bit         tx[$];
  logic [7:0] yr, mo, dy, hr, mi;
  logic [2:0] dw;
  bit         a2;
  int         nb, mode, sub;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int x);
    return 8'(((x / 10) << 4) + (x % 10));
  endfunction

  function automatic int fld(input int lo, input int w);
    int v = 0;
    for (int k = 0; k < w; k++) v += int'(mq[lo + k]) << k;
    return v;
  endfunction

  function automatic bit even(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(mq[i]);
    return (c % 2) == 0;
  endfunction

  function automatic bit model_frame_good();
    int n = mq.size();
    int mu, mt, hu, ht, du, dt, dwk, ou, ot, yu;
    if (!((n == 59) || (n == 60 && mq[19] == 1'b1 && mq[59] == 1'b0))) return 1'b0;
    if (mq[0] != 1'b0 || mq[20] != 1'b1) return 1'b0;
    if (!even(21, 28) || !even(29, 35) || !even(36, 58)) return 1'b0;
    mu = fld(21, 4); mt = fld(25, 3); hu = fld(29, 4); ht = fld(33, 2);
    du = fld(36, 4); dt = fld(40, 2); dwk = fld(42, 3);
    ou = fld(45, 4); ot = fld(49, 1); yu = fld(50, 4);
    if (mu > 9 || hu > 9 || du > 9 || ou > 9 || yu > 9) return 1'b0;
    if (mt * 10 + mu > 59 || ht * 10 + hu > 23) return 1'b0;
    if (dt * 10 + du < 1 || dt * 10 + du > 31) return 1'b0;
    if (ot * 10 + ou < 1 || ot * 10 + ou > 12 || dwk < 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_synced = 1'b0; mq.delete(); m_sec = 0; m_miss = 0;
    m_valid = 1'b0; m_ok = 1'b0; m_err = 1'b0;
    m_year = '0; m_month = '0; m_day = '0; m_hour = '0; m_minute = '0; m_dow = '0;
  endtask

  task automatic model_reject();
    m_err = 1'b1;
    if (m_miss < 15) m_miss++;
    if (m_miss >= MAX_MISSED) m_valid = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit m);
    int lim;
    m_ok = 1'b0; m_err = 1'b0;
    if (m) begin
      if (m_synced) begin
        m_sec = 0;
        if (model_frame_good()) begin
          m_minute = 8'(fld(25, 3) * 16 + fld(21, 4));
          m_hour   = 8'(fld(33, 2) * 16 + fld(29, 4));
          m_day    = 8'(fld(40, 2) * 16 + fld(36, 4));
          m_dow    = 3'(fld(42, 3));
          m_month  = 8'(fld(49, 1) * 16 + fld(45, 4));
          m_year   = 8'(fld(54, 4) * 16 + fld(50, 4));
          m_valid = 1'b1; m_miss = 0; m_ok = 1'b1;
        end else begin
          model_reject();
        end
      end
      m_synced = 1'b1;
      mq.delete();
    end else if (s && m_synced) begin
      if (mq.size() == 60) begin
        model_reject();
        m_synced = 1'b0;
      end else begin
        lim = (mq.size() > 19 && mq[19]) ? 60 : 59;
        if (m_sec < lim) m_sec++;
        mq.push_back(v);
      end
    end
  endtask

  task automatic check_all();
    check("year", year, m_year);
    check("month", month, m_month);
    check("day", day, m_day);
    check("hour", hour, m_hour);
    check("minute", minute, m_minute);
    check("second", second, bcd(m_sec));
    check("day_of_week", day_of_week, m_dow);
    check("valid", valid, m_valid);
    check("frame_ok", frame_ok, m_ok);
    check("frame_error", frame_error, m_err);
  endtask

  task automatic cyc(input bit s, input bit v, input bit m);
    @(negedge clk);
    bit_strobe = s; bit_value = v; minute_mark = m;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0; minute_mark = 1'b0;
    model_step(s, v, m);
    check_all();
  endtask

  task automatic send_bits(input int gap);
    foreach (tx[i]) begin
      cyc(1'b1, tx[i], 1'b0);
      repeat ($urandom_range(0, gap)) cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic put(input int lo, input int w, input logic [7:0] val);
    for (int k = 0; k < w; k++) fb[lo + k] = val[k];
  endtask

  task automatic parity_fill(input int lo, input int hi);
    bit p = 1'b0;
    for (int i = lo; i <= hi; i++) p ^= fb[i];
    fb[hi + 1] = p;
  endtask

  // Builds a frame from BCD bytes; units nibbles above 9 are passed through untouched.
  task automatic make_frame(input logic [7:0] y, input logic [7:0] mon, input logic [7:0] d,
                            input logic [2:0] wd, input logic [7:0] h, input logic [7:0] mn,
                            input bit leap_a2, input int nbits);
    for (int i = 0; i < 60; i++) fb[i] = (i >= 1 && i <= 18) ? bit'($urandom_range(0, 1)) : 1'b0;
    fb[19] = leap_a2;
    fb[20] = 1'b1;
    put(21, 4, mn); put(25, 3, mn >> 4); parity_fill(21, 27);
    put(29, 4, h);  put(33, 2, h >> 4);  parity_fill(29, 34);
    put(36, 4, d);  put(40, 2, d >> 4);  put(42, 3, 8'(wd));
    put(45, 4, mon); put(49, 1, mon >> 4);
    put(50, 4, y);  put(54, 4, y >> 4);  parity_fill(36, 57);
    tx.delete();
    for (int i = 0; i < nbits; i++) tx.push_back(fb[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Unsynchronised strobes are ignored; first mark only syncs.
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("sync_no_pulse", {frame_ok, frame_error}, 2'b00);

    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h37, 1'b0, 59);
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    check("tp_year", year, 8'h24);
    check("tp_month", month, 8'h03);
    check("tp_day", day, 8'h15);
    check("tp_dow", day_of_week, 3'd5);
    check("tp_hour", hour, 8'h14);
    check("tp_minute", minute, 8'h37);
    check("tp_second", second, 8'h00);
    check("tp_valid", valid, 1'b1);
    check("tp_frame_ok", frame_ok, 1'b1);

    // Seconds counting, then 70 strobes: saturation and overflow on the 61st.
    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h38, 1'b0, 59);
    for (int i = 0; i < 10; i++) cyc(1'b1, tx[i], 1'b0);
    check("sec_10", second, 8'h10);
    for (int i = 10; i < 59; i++) cyc(1'b1, tx[i], 1'b0);
    for (int i = 59; i < 70; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 60) check("overflow_err", frame_error, 1'b1);
    end
    check("sec_sat", second, 8'h59);
    cyc(1'b0, 1'b0, 1'b1);
    check("hunt_resync_no_pulse", {frame_ok, frame_error}, 2'b00);
    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h39, 1'b0, 59);
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    check("after_hunt_ok", frame_ok, 1'b1);

    // Parity faults: one miss keeps valid, the second drops it.
    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h40, 1'b0, 59);
    tx[35] = ~tx[35];
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    check("p2_err", frame_error, 1'b1);
    check("p2_minute_held", minute, 8'h39);
    check("p2_valid_kept", valid, 1'b1);
    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h41, 1'b0, 59);
    tx[35] = ~tx[35];
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    check("p2_valid_drop", valid, 1'b0);

    // Leap second frame, then the same bits without A2.
    make_frame(8'h24, 8'h03, 8'h15, 3'd5, 8'h14, 8'h42, 1'b0, 59);
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    make_frame(8'h24, 8'h06, 8'h30, 3'd7, 8'h23, 8'h59, 1'b1, 60);
    send_bits(0);
    check("leap_sec_60", second, 8'h60);
    cyc(1'b0, 1'b0, 1'b1);
    check("leap_ok", frame_ok, 1'b1);
    tx[19] = 1'b0;
    send_bits(0);
    cyc(1'b0, 1'b0, 1'b1);
    check("leap_no_a2_err", frame_error, 1'b1);

    // Reset mid-frame, resync, and a mark coinciding with a strobe.
    make_frame(8'h25, 8'h01, 8'h01, 3'd3, 8'h00, 8'h00, 1'b0, 59);
    for (int i = 0; i < 30; i++) cyc(1'b1, tx[i], 1'b0);
    do_reset();
    check("rst_valid", valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("rst_sync_no_pulse", {frame_ok, frame_error}, 2'b00);
    send_bits(1);
    cyc(1'b1, 1'b1, 1'b1);
    check("rst_then_ok", frame_ok, 1'b1);
    make_frame(8'h25, 8'h01, 8'h01, 3'd3, 8'h00, 8'h01, 1'b0, 59);
    send_bits(1);
    cyc(1'b0, 1'b0, 1'b1);
    check("simul_bit_dropped", frame_ok, 1'b1);

    // Randomized frames with assorted faults.
    for (int f = 0; f < 30; f++) begin
      mode = int'($urandom_range(0, 7));
      yr = bcd(int'($urandom_range(0, 99)));
      mo = bcd(int'($urandom_range(1, 12)));
      dy = bcd(int'($urandom_range(1, 31)));
      dw = 3'($urandom_range(1, 7));
      hr = bcd(int'($urandom_range(0, 23)));
      mi = bcd(int'($urandom_range(0, 59)));
      a2 = bit'($urandom_range(0, 1));
      nb = 59;
      sub = int'($urandom_range(0, 4));
      case (mode)
        4: nb = ($urandom_range(0, 1) == 1) ? 58 : 60;
        5: case (sub)
             0: mi = bcd(int'($urandom_range(60, 79)));
             1: hr = bcd(int'($urandom_range(24, 39)));
             2: dy = ($urandom_range(0, 1) == 1) ? 8'h00 : bcd(int'($urandom_range(32, 39)));
             3: mo = ($urandom_range(0, 1) == 1) ? 8'h00 : bcd(int'($urandom_range(13, 19)));
             default: dw = 3'd0;
           endcase
        6: case (sub)
             0: mi[3:0] = 4'($urandom_range(10, 15));
             1: hr[3:0] = 4'($urandom_range(10, 15));
             2: dy[3:0] = 4'($urandom_range(10, 15));
             3: mo[3:0] = 4'($urandom_range(10, 15));
             default: yr[3:0] = 4'($urandom_range(10, 15));
           endcase
        default: ;
      endcase
      make_frame(yr, mo, dy, dw, hr, mi, a2, nb);
      if (mode == 3) begin
        sub = int'($urandom_range(0, 58));
        tx[sub] = ~tx[sub];
      end
      if (mode == 4 && nb == 60) tx[59] = bit'($urandom_range(0, 1));
      send_bits(2);
      if (mode == 7) repeat ($urandom_range(2, 4)) cyc(1'b1, bit'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) cyc(1'b1, bit'($urandom_range(0, 1)), 1'b1);
      else                           cyc(1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
